// File: rtl/ps2_host_tx.sv
// ps2_host_tx: PS/2 host-to-device transmitter. It sends one command byte with odd parity to the
// attached device over the shared open-drain PS2_CLK/PS2_DATA lines. The lines are driven only
// while a transfer is in progress.
// Optional feature: define PS2_TX_RETRY_EN to retry a failed frame (NACK or timeout) up to two
// times with the same byte before tx_err is reported.
module ps2_host_tx #(
    parameter int unsigned INHIBIT_CYCLES = 10000,
    parameter int unsigned TIMEOUT_CYCLES = 2000000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       tx_done,
    output logic       tx_err,
    output logic       busy,
    inout  wire        PS2_CLK,
    inout  wire        PS2_DATA
);

    localparam int unsigned INH_W = $clog2(INHIBIT_CYCLES + 1);
    localparam int unsigned TO_W  = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [INH_W-1:0] INH_LAST = INH_W'(INHIBIT_CYCLES - 1);
    localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        StIdle,
        StInhibit,
        StRts,
        StSend,
        StAck,
        StDoneWait,
        StErr
    } state_t;

    state_t r_state;
    state_t w_state_next;

    // Line synchronizers; the extra clock stage gives the previous sample for edge detection.
    logic r_clk_meta;
    logic r_clk_sync;
    logic r_clk_prev;
    logic r_data_meta;
    logic r_data_sync;

    // Datapath
    logic [8:0]       r_frame;    // {odd parity, data}
    logic [INH_W-1:0] r_inh_cnt;
    logic [TO_W-1:0]  r_to_cnt;
    logic [3:0]       r_bit_cnt;
    logic             r_data_low; // PS2_DATA drive request while in RTS/SEND

    logic w_fe;
    logic w_accept;
    logic w_inh_done;
    logic w_timeout;
    logic w_ack_ok;
    logic w_nack;
    logic w_fail;
    logic w_retry;
    logic w_lines_idle;
    logic w_clk_low;
    logic w_data_low;

    assign w_fe         = r_clk_prev & ~r_clk_sync;
    assign w_accept     = (r_state == StIdle) && tx_valid;
    assign w_inh_done   = (r_state == StInhibit) && (r_inh_cnt == INH_LAST);
    assign w_timeout    = ((r_state == StSend) || (r_state == StAck)) && (r_to_cnt == TO_LAST);
    assign w_ack_ok     = (r_state == StAck) && w_fe && !r_data_sync;
    assign w_nack       = (r_state == StAck) && w_fe && r_data_sync;
    // A sampled ack on the same cycle as the timeout still counts as a good ack.
    assign w_fail       = w_nack || (w_timeout && !w_ack_ok);
    assign w_lines_idle = r_clk_sync && r_data_sync;

    assign PS2_CLK  = w_clk_low  ? 1'b0 : 1'bz;
    assign PS2_DATA = w_data_low ? 1'b0 : 1'bz;

    // Two-flop synchronizers for both lines (idle level is high)
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_clk_meta  <= 1'b1;
            r_clk_sync  <= 1'b1;
            r_clk_prev  <= 1'b1;
            r_data_meta <= 1'b1;
            r_data_sync <= 1'b1;
        end else begin
            r_clk_meta  <= PS2_CLK;
            r_clk_sync  <= r_clk_meta;
            r_clk_prev  <= r_clk_sync;
            r_data_meta <= PS2_DATA;
            r_data_sync <= r_data_meta;
        end
    end

`ifdef PS2_TX_RETRY_EN
    logic [1:0] r_retry_cnt;

    // Count consecutive failures of the current byte; a fresh accept starts over
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_retry_cnt <= '0;
        end else if (w_accept) begin
            r_retry_cnt <= '0;
        end else if (w_retry) begin
            r_retry_cnt <= r_retry_cnt + 1'b1;
        end
    end

    assign w_retry = w_fail && (r_retry_cnt != 2'd2);
`else
    assign w_retry = 1'b0;
`endif

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            StIdle: begin
                if (w_accept) w_state_next = StInhibit;
            end
            StInhibit: begin
                if (w_inh_done) w_state_next = StRts;
            end
            StRts: begin
                w_state_next = StSend;
            end
            StSend: begin
                if (w_fail) begin
                    w_state_next = w_retry ? StInhibit : StErr;
                end else if (w_fe && (r_bit_cnt == 4'd9)) begin
                    w_state_next = StAck;
                end
            end
            StAck: begin
                if (w_ack_ok) begin
                    w_state_next = StDoneWait;
                end else if (w_fail) begin
                    w_state_next = w_retry ? StInhibit : StErr;
                end
            end
            StDoneWait: begin
                if (w_lines_idle) w_state_next = StIdle;
            end
            StErr: begin
                w_state_next = StIdle;
            end
            default: begin
                w_state_next = StIdle;
            end
        endcase
    end

    // Outputs and line drivers, decoded from the current state only (reset releases at once)
    always_comb begin
        tx_ready   = 1'b0;
        busy       = 1'b1;
        tx_done    = 1'b0;
        tx_err     = 1'b0;
        w_clk_low  = 1'b0;
        w_data_low = 1'b0;
        unique case (r_state)
            StIdle: begin
                tx_ready = 1'b1;
                busy     = 1'b0;
            end
            StInhibit: begin
                w_clk_low = 1'b1;
            end
            StRts, StSend: begin
                w_data_low = r_data_low;
            end
            StAck: begin
            end
            StDoneWait: begin
                tx_done = w_lines_idle;
            end
            StErr: begin
                tx_err = 1'b1;
            end
            default: begin
            end
        endcase
    end

    // Frame latch, counters and the data-bit shifter
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_frame    <= '0;
            r_inh_cnt  <= '0;
            r_to_cnt   <= '0;
            r_bit_cnt  <= '0;
            r_data_low <= 1'b0;
        end else begin
            if (w_accept) begin
                r_frame <= {~^tx_data, tx_data};
            end

            r_inh_cnt <= (r_state == StInhibit) ? r_inh_cnt + 1'b1 : '0;

            // Cleared in RTS, so it measures time since the clock line was released
            r_to_cnt <= ((r_state == StSend) || (r_state == StAck)) ? r_to_cnt + 1'b1 : '0;

            if (r_state != StSend) begin
                r_bit_cnt <= '0;
            end else if (w_fe) begin
                r_bit_cnt <= r_bit_cnt + 1'b1;
            end

            // Start bit from end of inhibit; then d0..d7, parity, and release for the stop bit
            if (w_inh_done) begin
                r_data_low <= 1'b1;
            end else if (r_state == StSend) begin
                if (w_fe) begin
                    r_data_low <= (r_bit_cnt == 4'd9) ? 1'b0 : ~r_frame[r_bit_cnt];
                end
            end else if (r_state != StRts) begin
                r_data_low <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_ps2_host_tx.sv
// Self-checking bench for ps2_host_tx with a behavioural PS/2 device model on pulled-up lines.
module tb_ps2_host_tx;

    localparam int INH = 200;
    localparam int TO  = 3000;
    localparam int HP  = 20;
`ifdef PS2_TX_RETRY_EN
    localparam int ATTEMPTS = 3;
`else
    localparam int ATTEMPTS = 1;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [7:0] tx_data = 8'h00;
    logic       tx_valid = 1'b0;
    logic       tx_ready;
    logic       tx_done;
    logic       tx_err;
    logic       busy;
    wire        ps2_clk;
    wire        ps2_data;
    logic       dev_clk_low = 1'b0;
    logic       dev_data_low = 1'b0;

    pullup (ps2_clk);
    pullup (ps2_data);
    assign ps2_clk  = dev_clk_low  ? 1'b0 : 1'bz;
    assign ps2_data = dev_data_low ? 1'b0 : 1'bz;

    ps2_host_tx #(
        .INHIBIT_CYCLES(INH),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .tx_data (tx_data),
        .tx_valid(tx_valid),
        .tx_ready(tx_ready),
        .tx_done (tx_done),
        .tx_err  (tx_err),
        .busy    (busy),
        .PS2_CLK (ps2_clk),
        .PS2_DATA(ps2_data)
    );

    always #5 clk = ~clk;

    int   total = 0;
    int   bad = 0;
    int   cyc = 0;
    int   done_cnt = 0;
    int   err_cnt = 0;
    int   both_cnt = 0;
    int   inh_cnt = 0;
    int   inh_run = 0;
    int   low_run = 0;
    int   last_release = 0;
    int   last_err_cyc = 0;
    logic prev_clk = 1'b1;

    // Line and pulse monitor
    always @(negedge clk) begin
        cyc <= cyc + 1;
        if (tx_done === 1'b1) done_cnt <= done_cnt + 1;
        if (tx_err === 1'b1) begin
            err_cnt      <= err_cnt + 1;
            last_err_cyc <= cyc;
        end
        if (tx_done === 1'b1 && tx_err === 1'b1) both_cnt <= both_cnt + 1;
        if (ps2_clk === 1'b0) begin
            low_run <= low_run + 1;
        end else begin
            if (prev_clk === 1'b0) begin
                last_release <= cyc;
                if (low_run >= INH) begin
                    inh_cnt <= inh_cnt + 1;
                    inh_run <= low_run;
                end
            end
            low_run <= 0;
        end
        prev_clk <= ps2_clk;
    end

    task automatic wait_clk(input logic v, input int lim, output logic ok);
        for (int i = 0; i < lim && ps2_clk !== v; i++) @(negedge clk);
        ok = (ps2_clk === v);
    endtask

    task automatic request(input logic [7:0] b);
        @(negedge clk);
        tx_data  = b;
        tx_valid = 1'b1;
        @(negedge clk);
        tx_valid = 1'b0;
    endtask

    // Device side: wait for inhibit + release, read the start bit, then clock out pulses
    task automatic dev_frame(input logic ack_low, input int pulses, output logic [10:0] bits,
                             output logic ok);
        logic ok2;
        bits = '1;
        wait_clk(1'b0, 100, ok);
        wait_clk(1'b1, INH + 100, ok2);
        ok = ok & ok2;
        if (ok) begin
            repeat (10) @(negedge clk);
            bits[0] = ps2_data;
            for (int p = 1; p <= pulses; p++) begin
                dev_clk_low = 1'b1;
                repeat (HP) @(negedge clk);
                if (p <= 10) bits[p] = ps2_data;
                dev_clk_low = 1'b0;
                if (p == 10 && ack_low) dev_data_low = 1'b1;
                repeat (HP) @(negedge clk);
                if (p == 11) dev_data_low = 1'b0;
            end
        end
    endtask

    task automatic test_reset;
        rst = 1'b0;
        repeat (3) @(negedge clk);
        total++; if (tx_ready !== 1'b1) begin bad++; $display("FAIL rst_ready got %b want 1", tx_ready); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_busy got %b want 0", busy); end
        total++; if (tx_done !== 1'b0) begin bad++; $display("FAIL rst_done got %b want 0", tx_done); end
        total++; if (tx_err !== 1'b0) begin bad++; $display("FAIL rst_err got %b want 0", tx_err); end
        total++; if (ps2_clk !== 1'b1) begin bad++; $display("FAIL rst_clk got %b want 1", ps2_clk); end
        total++; if (ps2_data !== 1'b1) begin bad++; $display("FAIL rst_data got %b want 1", ps2_data); end
        rst = 1'b1;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_send(input logic [7:0] b, input logic [7:0] exp_byte, input logic exp_par);
        logic [10:0] bits;
        logic        ok;
        int          d0, e0, i0;
        d0 = done_cnt; e0 = err_cnt; i0 = inh_cnt;
        request(b);
        dev_frame(1'b1, 11, bits, ok);
        repeat (20) @(negedge clk);
        total++; if (!ok) begin bad++; $display("FAIL send_%h_wait got timeout want lines", b); end
        total++; if (bits[0] !== 1'b0) begin bad++; $display("FAIL send_%h_start got %b want 0", b, bits[0]); end
        total++; if (bits[8:1] !== exp_byte) begin bad++; $display("FAIL send_%h_data got %h want %h", b, bits[8:1], exp_byte); end
        total++; if (bits[9] !== exp_par) begin bad++; $display("FAIL send_%h_parity got %b want %b", b, bits[9], exp_par); end
        total++; if (bits[10] !== 1'b1) begin bad++; $display("FAIL send_%h_stop got %b want 1", b, bits[10]); end
        total++; if (done_cnt - d0 != 1) begin bad++; $display("FAIL send_%h_done got %0d want 1", b, done_cnt - d0); end
        total++; if (err_cnt != e0) begin bad++; $display("FAIL send_%h_err got %0d want 0", b, err_cnt - e0); end
        total++; if (busy !== 1'b0 || tx_ready !== 1'b1) begin bad++; $display("FAIL send_%h_idle got busy=%b want 0", b, busy); end
        total++; if (inh_cnt - i0 != 1 || inh_run < INH) begin bad++; $display("FAIL send_%h_inhibit got %0d cycles want >=%0d", b, inh_run, INH); end
    endtask

    task automatic test_timeout;
        int e0, d0, i0, diff;
        e0 = err_cnt; d0 = done_cnt; i0 = inh_cnt;
        request(8'h55);
        for (int i = 0; i < ATTEMPTS * (INH + TO + 100) && err_cnt == e0; i++) @(negedge clk);
        repeat (3) @(negedge clk);
        diff = last_err_cyc - last_release;
        total++; if (err_cnt - e0 != 1) begin bad++; $display("FAIL timeout_err got %0d want 1", err_cnt - e0); end
        total++; if (diff < TO - 2 || diff > TO + 2) begin bad++; $display("FAIL timeout_time got %0d want %0d", diff, TO); end
        total++; if (ps2_clk !== 1'b1 || ps2_data !== 1'b1) begin bad++; $display("FAIL timeout_lines got %b%b want 11", ps2_clk, ps2_data); end
        total++; if (tx_ready !== 1'b1) begin bad++; $display("FAIL timeout_ready got %b want 1", tx_ready); end
        total++; if (done_cnt != d0) begin bad++; $display("FAIL timeout_done got %0d want 0", done_cnt - d0); end
        total++; if (inh_cnt - i0 != ATTEMPTS) begin bad++; $display("FAIL timeout_inhibits got %0d want %0d", inh_cnt - i0, ATTEMPTS); end
    endtask

    task automatic test_nack;
        logic [10:0] bits;
        logic        ok;
        logic        all_ok;
        int          e0, d0, i0;
        e0 = err_cnt; d0 = done_cnt; i0 = inh_cnt; all_ok = 1'b1;
        request(8'h81);
        for (int k = 0; k < ATTEMPTS; k++) begin
            dev_frame(1'b0, 11, bits, ok);
            all_ok = all_ok & ok;
        end
        repeat (20) @(negedge clk);
        total++; if (!all_ok) begin bad++; $display("FAIL nack_wait got timeout want lines"); end
        total++; if (bits[8:1] !== 8'h81 || bits[9] !== 1'b1) begin bad++; $display("FAIL nack_frame got %h/%b want 81/1", bits[8:1], bits[9]); end
        total++; if (err_cnt - e0 != 1) begin bad++; $display("FAIL nack_err got %0d want 1", err_cnt - e0); end
        total++; if (done_cnt != d0) begin bad++; $display("FAIL nack_done got %0d want 0", done_cnt - d0); end
        total++; if (inh_cnt - i0 != ATTEMPTS) begin bad++; $display("FAIL nack_inhibits got %0d want %0d", inh_cnt - i0, ATTEMPTS); end
    endtask

    task automatic test_reset_mid;
        logic [10:0] bits;
        logic        ok;
        request(8'hA5);
        dev_frame(1'b1, 4, bits, ok);
        dev_clk_low = 1'b1;
        repeat (6) @(negedge clk);
        total++; if (ps2_data !== 1'b0) begin bad++; $display("FAIL mid_d4_driven got %b want 0", ps2_data); end
        rst = 1'b0;
        #1;
        total++; if (ps2_data !== 1'b1) begin bad++; $display("FAIL mid_rst_data got %b want 1", ps2_data); end
        total++; if (tx_ready !== 1'b1 || busy !== 1'b0) begin bad++; $display("FAIL mid_rst_ready got %b want 1", tx_ready); end
        dev_clk_low = 1'b0;
        #1;
        total++; if (ps2_clk !== 1'b1) begin bad++; $display("FAIL mid_rst_clk got %b want 1", ps2_clk); end
        @(negedge clk);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        test_send(8'hFF, 8'hFF, 1'b1);
    endtask

    task automatic test_back_to_back;
        logic [10:0] bits;
        logic        ok;
        int          d0, i0;
        d0 = done_cnt; i0 = inh_cnt;
        @(negedge clk);
        tx_data  = 8'h3C;
        tx_valid = 1'b1;
        @(negedge clk);
        tx_data  = 8'hC3;
        dev_frame(1'b1, 11, bits, ok);
        for (int i = 0; i < 30 && tx_done !== 1'b1; i++) @(negedge clk);
        total++; if (tx_done !== 1'b1) begin bad++; $display("FAIL b2b_done1 got %b want 1", tx_done); end
        total++; if (!ok || bits[8:1] !== 8'h3C || bits[9] !== 1'b1) begin bad++; $display("FAIL b2b_frame1 got %h/%b want 3c/1", bits[8:1], bits[9]); end
        @(negedge clk);
        total++; if (tx_ready !== 1'b1) begin bad++; $display("FAIL b2b_idle got %b want 1", tx_ready); end
        @(negedge clk);
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL b2b_accept2 got %b want 1", busy); end
        tx_valid = 1'b0;
        total++; if (inh_cnt - i0 != 1) begin bad++; $display("FAIL b2b_one_frame got %0d want 1", inh_cnt - i0); end
        dev_frame(1'b1, 11, bits, ok);
        repeat (20) @(negedge clk);
        total++; if (!ok || bits[8:1] !== 8'hC3 || bits[9] !== 1'b1) begin bad++; $display("FAIL b2b_frame2 got %h/%b want c3/1", bits[8:1], bits[9]); end
        total++; if (done_cnt - d0 != 2) begin bad++; $display("FAIL b2b_done_total got %0d want 2", done_cnt - d0); end
        total++; if (both_cnt != 0) begin bad++; $display("FAIL done_err_overlap got %0d want 0", both_cnt); end
    endtask

    initial begin
        test_reset();
        test_send(8'hED, 8'b1110_1101, 1'b1);
        test_send(8'h07, 8'h07, 1'b0);
        test_send(8'h00, 8'h00, 1'b1);
        test_timeout();
        test_nack();
        test_reset_mid();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
